beacon_div_sched: RTL and testbench
===================================

// Module: beacon_div_sched
// PURPOSE
// Round-robin scheduler that time-shares one phase-tick clock divider between NUM_BEACONS beacon LEDs.
// Each enabled beacon owns the divider for a slot of slot_len phase0 periods, using its own divisor.
// The block resets and reloads the divider between slots and gates its phase0 tick onto that beacon's LED.
// Divisors, slot length and enable mask are written through a valid/ready config port.
// PARAMETERS
// WIDTH        16   divisor width; matches divider N
// NUM_BEACONS  3    number of beacon outputs (>=2)
// SLOT_W       8    width of slot_len (phase0 periods per slot)
// DEFAULT_N    1000 reset value of every divisor register
// DEFAULT_SLOT 4    reset value of slot_len
// ADDR_W       $clog2(NUM_BEACONS+2), derived config address width
// PORTS
// clk          in   1            system clock
// rst_n        in   1            synchronous reset, active low
// en           in   1            run enable; low forces IDLE
// cfg_valid    in   1            config write request
// cfg_ready    out  1            config write accepted when valid&ready
// cfg_addr     in   ADDR_W       0..NB-1: divisor[i]; NB: slot_len; NB+1: mask; others ignored
// cfg_data     in   WIDTH        write data; slot_len uses [SLOT_W-1:0], mask uses [NB-1:0]
// div_rst      out  1            divider reset (active high), drives divider reload
// div_en       out  1            divider count enable
// div_N        out  WIDTH        divisor presented to divider
// tick_phase0  in   1            divider phase0 output
// beacon_sel   out  NUM_BEACONS  one-hot owner of current slot, 0 when idle
// beacon_out   out  NUM_BEACONS  LED drive = registered (beacon_sel & tick_phase0)
// slot_done    out  1            1-cycle pulse on the cycle a slot ends
// BEHAVIOUR
// Reset (rst_n=0 at posedge): state=IDLE, div_rst=1, div_en=0, div_N=DEFAULT_N, beacon_sel=0,
//   beacon_out=0, slot_done=0, cfg_ready=0, divisor[*]=DEFAULT_N, slot_len=DEFAULT_SLOT, mask=all ones,
//   cur=NB-1 (first search gives beacon 0), period_cnt=0, tick_q=0. Reset mid-slot discards the slot.
// FSM IDLE: div_rst=1, div_en=0, beacon_sel=0. en=1 and mask!=0 -> LOAD; cur <= next enabled after cur.
// FSM LOAD (exactly 1 cycle): div_rst=1, div_N<=divisor[cur], period_cnt<=0, beacon_sel<=onehot(cur) -> RUN.
// FSM RUN: div_rst=0, div_en=1. Phase0 rise = tick_phase0 & ~tick_q (tick_q = tick_phase0 delayed 1 cycle).
//   Each rise increments period_cnt. A rise with period_cnt==max(slot_len,1)-1 ends the slot:
//   slot_done=1 in that cycle, cur<=next enabled. Then -> LOAD, or -> IDLE if the mask has just
//   become 0 (beacon_sel cleared).
// Next-enabled search: round-robin from cur+1 with wrap. A sole enabled beacon re-selects itself,
//   but still passes through LOAD, so the divider restarts.
// en=0 in LOAD/RUN -> IDLE next cycle, beacon_out cleared the same cycle; no slot_done.
// beacon_out: 1-cycle latency from tick_phase0; 0 in IDLE/LOAD.
// Config: cfg_ready=1 in IDLE and RUN, 0 in LOAD and reset. A write lands on the accepting edge.
//   A divisor write to the current beacon takes effect at its next LOAD, never mid-slot.
//   slot_len and mask writes apply immediately to slot-end compare and search.
//   slot_len=0 behaves as 1.
// Simultaneous slot end and config write: the write lands first, and the next-enabled search uses the new mask.
// Divisor 0: divider ticks phase0 every cycle; legal, no special case.
// TESTING
// T1 reset: rst_n=0 2 cycles, en=0 -> div_rst=1, beacon_sel=0, beacon_out=0, cfg_ready=0 then 1.
// T2 rotation: N={3,5,7}, slot_len=2, mask=3'b111, en=1 -> sel 001,010,100,001...;
//   slot_done after 2 phase0 rises each; div_N matches owner.
// T3 mask skip: mask=3'b101 mid-slot of beacon0 -> next owner beacon2, then beacon0; beacon1 never selected.
// T4 live divisor write: write N[cur]=9 during RUN -> div_N unchanged until that beacon's next LOAD.
// T5 abort: en=0 (or rst_n=0) mid-RUN -> next cycle IDLE, div_rst=1, beacon_out=0, no slot_done.
// T6 edge cases: slot_len=0 -> 1-period slots; mask=0 during RUN -> IDLE after slot_done;
//   cfg_valid held through LOAD -> accepted only after ready returns.

Source files
------------

// File: rtl/beacon_div_sched.sv
// Round-robin scheduler sharing one phase-tick divider between several beacon LEDs.
// Each enabled beacon owns the divider for slot_len phase0 periods using its own divisor.
module beacon_div_sched #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NUM_BEACONS  = 3,
    parameter int unsigned SLOT_W       = 8,
    parameter int unsigned DEFAULT_N    = 1000,
    parameter int unsigned DEFAULT_SLOT = 4,
    parameter int unsigned ADDR_W       = $clog2(NUM_BEACONS + 2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [WIDTH-1:0]       cfg_data,
    output logic                   div_rst,
    output logic                   div_en,
    output logic [WIDTH-1:0]       div_N,
    input  logic                   tick_phase0,
    output logic [NUM_BEACONS-1:0] beacon_sel,
    output logic [NUM_BEACONS-1:0] beacon_out,
    output logic                   slot_done
);

    localparam int unsigned CUR_W = (NUM_BEACONS > 1) ? $clog2(NUM_BEACONS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [CUR_W-1:0]       cur_q, cur_d;
    logic [WIDTH-1:0]       div_n_q, div_n_d;
    logic [SLOT_W-1:0]      period_cnt_q, period_cnt_d;
    logic [NUM_BEACONS-1:0] sel_q, sel_d;
    logic [NUM_BEACONS-1:0] out_q, out_d;
    logic                   tick_q;

    logic [WIDTH-1:0]       divisor_q [NUM_BEACONS];
    logic [SLOT_W-1:0]      slot_len_q;
    logic [NUM_BEACONS-1:0] mask_q;

    logic                   cfg_we, wr_div, wr_slot, wr_mask;
    logic [SLOT_W-1:0]      slot_len_eff, slot_last;
    logic [NUM_BEACONS-1:0] mask_eff, cur_onehot;
    logic                   rise, slot_end;
    logic [CUR_W-1:0]       next_cur, cand;
    logic                   found;

    assign cfg_ready = rst_n & (state_q != StLoad);
    assign cfg_we    = cfg_valid & cfg_ready;
    assign wr_div    = cfg_we && (cfg_addr < ADDR_W'(NUM_BEACONS));
    assign wr_slot   = cfg_we && (cfg_addr == ADDR_W'(NUM_BEACONS));
    assign wr_mask   = cfg_we && (cfg_addr == ADDR_W'(NUM_BEACONS + 1));

    // A write accepted this cycle already counts for the slot-end compare and the search.
    assign slot_len_eff = wr_slot ? cfg_data[SLOT_W-1:0] : slot_len_q;
    assign mask_eff     = wr_mask ? cfg_data[NUM_BEACONS-1:0] : mask_q;
    assign slot_last    = (slot_len_eff == '0) ? '0 : slot_len_eff - SLOT_W'(1);

    assign rise       = tick_phase0 & ~tick_q;
    assign cur_onehot = NUM_BEACONS'(1) << cur_q;

    always_comb begin
        next_cur = cur_q;
        cand     = '0;
        found    = 1'b0;
        for (int unsigned k = 1; k <= NUM_BEACONS; k++) begin
            cand = CUR_W'((32'(cur_q) + k) % NUM_BEACONS);
            if (!found && mask_eff[cand]) begin
                next_cur = cand;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        div_n_d      = div_n_q;
        period_cnt_d = period_cnt_q;
        sel_d        = sel_q;
        slot_end     = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                if (en && (mask_eff != '0)) begin
                    state_d = StLoad;
                    cur_d   = next_cur;
                end
            end
            StLoad: begin
                if (!en) begin
                    state_d = StIdle;
                    sel_d   = '0;
                end else begin
                    div_n_d      = divisor_q[cur_q];
                    period_cnt_d = '0;
                    sel_d        = cur_onehot;
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    sel_d   = '0;
                end else if (rise) begin
                    if (period_cnt_q == slot_last) begin
                        slot_end     = 1'b1;
                        period_cnt_d = '0;
                        if (mask_eff == '0) begin
                            state_d = StIdle;
                            sel_d   = '0;
                        end else begin
                            state_d = StLoad;
                            cur_d   = next_cur;
                        end
                    end else begin
                        period_cnt_d = period_cnt_q + SLOT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    // LED drive only while the slot continues; leaving RUN clears it on the same edge.
    assign out_d = ((state_q == StRun) && (state_d == StRun)) ?
                   (sel_q & {NUM_BEACONS{tick_phase0}}) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cur_q        <= CUR_W'(NUM_BEACONS - 1);
            div_n_q      <= WIDTH'(DEFAULT_N);
            period_cnt_q <= '0;
            sel_q        <= '0;
            out_q        <= '0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            div_n_q      <= div_n_d;
            period_cnt_q <= period_cnt_d;
            sel_q        <= sel_d;
            out_q        <= out_d;
            tick_q       <= tick_phase0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_BEACONS); i++) begin
                divisor_q[i] <= WIDTH'(DEFAULT_N);
            end
            slot_len_q <= SLOT_W'(DEFAULT_SLOT);
            mask_q     <= '1;
        end else begin
            if (wr_div) begin
                divisor_q[cfg_addr[CUR_W-1:0]] <= cfg_data;
            end
            if (wr_slot) begin
                slot_len_q <= cfg_data[SLOT_W-1:0];
            end
            if (wr_mask) begin
                mask_q <= cfg_data[NUM_BEACONS-1:0];
            end
        end
    end

    assign div_rst    = (state_q != StRun);
    assign div_en     = (state_q == StRun);
    assign div_N      = div_n_q;
    assign beacon_sel = sel_q;
    assign beacon_out = out_q;
    assign slot_done  = slot_end & rst_n;

endmodule

// File: tb/tb_beacon_div_sched.sv
// Bench for beacon_div_sched: hand-derived vector table for the directed scenarios,
// then random stimulus compared against a slot-level behavioural model.
module tb_beacon_div_sched;

    logic        clk = 1'b0;
    logic        rst_n, en, cfg_valid, cfg_ready, tick_phase0;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data, div_N;
    logic        div_rst, div_en, slot_done;
    logic [2:0]  beacon_sel, beacon_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    beacon_div_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .div_rst    (div_rst),
        .div_en     (div_en),
        .div_N      (div_N),
        .tick_phase0(tick_phase0),
        .beacon_sel (beacon_sel),
        .beacon_out (beacon_out),
        .slot_done  (slot_done)
    );

    typedef struct {
        logic        rst_n, en, cv;
        logic [2:0]  ca;
        logic [15:0] cd;
        logic        tick;
        logic        ready, drst;
        logic [2:0]  sel, out;
        logic        done;
        logic [15:0] dn;
    } vec_t;

    function automatic vec_t v(input logic r, input logic e, input logic cv, input int ca,
                               input int cd, input logic t, input logic rdy, input logic drst,
                               input int sel, input int out, input logic done, input int dn);
        vec_t x;
        x.rst_n = r;  x.en = e;  x.cv = cv;  x.ca = 3'(ca);  x.cd = 16'(cd);  x.tick = t;
        x.ready = rdy;  x.drst = drst;  x.sel = 3'(sel);  x.out = 3'(out);  x.done = done;
        x.dn = 16'(dn);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 reload, 2 running a slot.
    int       m_phase, m_owner, m_periods, m_slot;
    int       m_div[3];
    int       m_div_n;
    bit [2:0] m_sel, m_out, m_mask;
    bit       m_tick_prev;
    bit       e_ready, e_accept, e_rise, e_end;
    bit [2:0] e_mask;
    int       e_slot;

    function automatic int next_owner(input int from, input bit [2:0] mk);
        for (int off = 1; off <= 3; off++) begin
            if (mk[(from + off) % 3]) return (from + off) % 3;
        end
        return from;
    endfunction

    task automatic model_eval();
        int len;
        e_ready  = rst_n && (m_phase != 1);
        e_accept = cfg_valid && e_ready;
        e_mask   = (e_accept && cfg_addr == 3'd4) ? cfg_data[2:0] : m_mask;
        e_slot   = (e_accept && cfg_addr == 3'd3) ? int'(cfg_data[7:0]) : m_slot;
        e_rise   = tick_phase0 && !m_tick_prev;
        len      = (e_slot == 0) ? 1 : e_slot;
        e_end    = rst_n && (m_phase == 2) && en && e_rise && (m_periods == len - 1);
    endtask

    task automatic model_step();
        int       nphase;
        bit [2:0] old_sel;
        model_eval();
        if (!rst_n) begin
            m_phase = 0;  m_owner = 2;  m_periods = 0;  m_slot = 4;  m_mask = 3'b111;
            m_div_n = 1000;  m_sel = 0;  m_out = 0;  m_tick_prev = 0;
            for (int i = 0; i < 3; i++) m_div[i] = 1000;
            return;
        end
        nphase  = m_phase;
        old_sel = m_sel;
        if (m_phase == 0) begin
            m_sel = 0;
            if (en && e_mask != 0) begin
                nphase  = 1;
                m_owner = next_owner(m_owner, e_mask);
            end
        end else if (!en) begin
            nphase = 0;
            m_sel  = 0;
        end else if (m_phase == 1) begin
            m_div_n   = m_div[m_owner];
            m_periods = 0;
            m_sel     = 3'(1 << m_owner);
            nphase    = 2;
        end else if (e_rise) begin
            if (e_end) begin
                m_periods = 0;
                if (e_mask == 0) begin
                    nphase = 0;
                    m_sel  = 0;
                end else begin
                    nphase  = 1;
                    m_owner = next_owner(m_owner, e_mask);
                end
            end else begin
                m_periods = (m_periods + 1) % 256;
            end
        end
        m_out = (m_phase == 2 && nphase == 2) ? (old_sel & {3{tick_phase0}}) : 3'b000;
        m_phase = nphase;
        if (e_accept) begin
            if (cfg_addr < 3'd3) m_div[cfg_addr] = int'(cfg_data);
            else if (cfg_addr == 3'd3) m_slot = int'(cfg_data[7:0]);
            else if (cfg_addr == 3'd4) m_mask = cfg_data[2:0];
        end
        m_tick_prev = tick_phase0;
    endtask

    // mode 0: no check, 1: check against the table row, 2: check against the model
    task automatic run_cycle(input vec_t r, input int mode, input string tag);
        @(negedge clk);
        rst_n = r.rst_n;  en = r.en;  cfg_valid = r.cv;  cfg_addr = r.ca;
        cfg_data = r.cd;  tick_phase0 = r.tick;
        #1;
        if (mode == 1) begin
            check({tag, ".ready"}, 32'(cfg_ready), 32'(r.ready));
            check({tag, ".div_rst"}, 32'(div_rst), 32'(r.drst));
            check({tag, ".div_en"}, 32'(div_en), 32'(!r.drst));
            check({tag, ".div_N"}, 32'(div_N), 32'(r.dn));
            check({tag, ".sel"}, 32'(beacon_sel), 32'(r.sel));
            check({tag, ".out"}, 32'(beacon_out), 32'(r.out));
            check({tag, ".slot_done"}, 32'(slot_done), 32'(r.done));
        end else if (mode == 2) begin
            model_eval();
            check({tag, ".ready"}, 32'(cfg_ready), 32'(e_ready));
            check({tag, ".div_rst"}, 32'(div_rst), 32'(m_phase != 2));
            check({tag, ".div_en"}, 32'(div_en), 32'(m_phase == 2));
            check({tag, ".div_N"}, 32'(div_N), 32'(m_div_n));
            check({tag, ".sel"}, 32'(beacon_sel), 32'(m_sel));
            check({tag, ".out"}, 32'(beacon_out), 32'(m_out));
            check({tag, ".slot_done"}, 32'(slot_done), 32'(e_end));
        end
        @(posedge clk);
        model_step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t r;
        logic en_lvl;

        // reset, program N={3,5,7}, slot_len=2, then rotate
        tbl.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,1000));
        tbl.push_back(v(1,0,0,0,0,0, 1,1,0,0,0,1000));
        tbl.push_back(v(1,0,1,0,3,0, 1,1,0,0,0,1000));
        tbl.push_back(v(1,0,1,1,5,0, 1,1,0,0,0,1000));
        tbl.push_back(v(1,0,1,2,7,0, 1,1,0,0,0,1000));
        tbl.push_back(v(1,0,1,3,2,0, 1,1,0,0,0,1000));
        tbl.push_back(v(1,0,1,4,7,0, 1,1,0,0,0,1000));
        tbl.push_back(v(1,1,0,0,0,0, 1,1,0,0,0,1000));
        tbl.push_back(v(1,1,0,0,0,0, 0,1,0,0,0,1000));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,1,0,0,3));
        tbl.push_back(v(1,1,0,0,0,0, 1,0,1,1,0,3));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,1,0,1,3));
        // mask=101 held through LOAD, accepted once RUN restores ready
        tbl.push_back(v(1,1,1,4,5,0, 0,1,1,0,0,3));
        tbl.push_back(v(1,1,1,4,5,0, 1,0,2,0,0,5));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,2,0,0,5));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,2,2,0,5));
        tbl.push_back(v(1,1,0,0,0,0, 1,0,2,2,0,5));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,2,0,1,5));
        tbl.push_back(v(1,1,0,0,0,0, 0,1,2,0,0,5));
        // beacon 2 running: its divisor rewritten to 9, div_N stays 7
        tbl.push_back(v(1,1,1,2,9,0, 1,0,4,0,0,7));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,4,0,0,7));
        tbl.push_back(v(1,1,0,0,0,0, 1,0,4,4,0,7));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,4,0,1,7));
        tbl.push_back(v(1,1,0,0,0,0, 0,1,4,0,0,7));
        // slot_len=0 gives one-period slots; beacon 1 skipped
        tbl.push_back(v(1,1,1,3,0,0, 1,0,1,0,0,3));
        tbl.push_back(v(1,1,0,0,0,1, 1,0,1,0,1,3));
        tbl.push_back(v(1,1,0,0,0,0, 0,1,1,0,0,3));
        // mask=0 written on the slot-end cycle -> idle
        tbl.push_back(v(1,1,1,4,0,1, 1,0,4,0,1,9));
        tbl.push_back(v(1,1,1,4,7,0, 1,1,0,0,0,9));
        tbl.push_back(v(1,1,0,0,0,0, 0,1,0,0,0,9));
        // en drop on a would-be slot end: no slot_done
        tbl.push_back(v(1,0,0,0,0,1, 1,0,1,0,0,3));
        tbl.push_back(v(1,0,0,0,0,0, 1,1,0,0,0,3));
        tbl.push_back(v(1,1,0,0,0,0, 1,1,0,0,0,3));
        tbl.push_back(v(1,1,0,0,0,0, 0,1,0,0,0,3));
        // reset mid-RUN discards the slot and the configuration
        tbl.push_back(v(0,1,0,0,0,1, 0,0,2,0,0,5));
        tbl.push_back(v(1,0,0,0,0,0, 1,1,0,0,0,1000));

        run_cycle(v(0,0,0,0,0,0, 0,0,0,0,0,0), 0, "init");
        foreach (tbl[i]) run_cycle(tbl[i], 1, $sformatf("tbl[%0d]", i));

        en_lvl = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 40) == 0) en_lvl = ~en_lvl;
            r = v(1, en_lvl, 0, 0, 0, 0, 0,0,0,0,0,0);
            r.rst_n = ($urandom_range(0, 299) != 0);
            r.tick  = 1'($urandom_range(0, 1));
            r.cv    = ($urandom_range(0, 5) == 0);
            r.ca    = 3'($urandom_range(0, 7));
            if (r.ca < 3) r.cd = 16'($urandom_range(0, 15));
            else if (r.ca == 3) r.cd = 16'({$urandom_range(0, 255), 8'($urandom_range(0, 3))});
            else r.cd = 16'($urandom);
            run_cycle(r, 2, $sformatf("rnd[%0d]", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
